// File: rtl/pipearch_writeback_pkg.sv
// ---------------------------------------------------------------------------
// pipearch_writeback_pkg
// Shared types and constants for the write-back path: CCI-P c1 channel
// structures, write-buffer sizing and writeback FSM state encodings.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipearch_writeback_pkg;

  localparam int LOG2_WRITEBUF_SIZE = 6;
  localparam int WRITEBUF_SIZE      = 1 << LOG2_WRITEBUF_SIZE;
  localparam int CL_ADDR_W          = 42;
  localparam int NUM_REGS           = 8;

  // Writeback FSM state encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
  typedef logic [511:0]         t_ccip_clData;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [5:0]   rsvd1;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd0;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd2;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  // True for a valid write-line response on c1 RX
  function automatic logic cci_c1Rx_isWriteRsp(input t_if_ccip_c1_Rx r);
    return r.rspValid && (r.hdr.resp_type == eRSP_WRLINE);
  endfunction

  // Number of lines acknowledged by one write response (packed or single)
  function automatic logic [31:0] rsp_line_count(input t_if_ccip_c1_Rx r);
    return r.hdr.format ? (32'(r.hdr.cl_num) + 32'd1) : 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipearch_writeback_if.sv
// ---------------------------------------------------------------------------
// pipearch_writeback_if
// Engine write stream plus CCI-P c1 TX/RX bundle for the writeback unit.
// master = engine/shell side, slave = writeback unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipearch_writeback_if;
  import pipearch_writeback_pkg::*;

  logic           wr_valid;
  t_ccip_clData   wr_data;
  logic           wr_ready;
  logic           c1TxAlmFull;
  t_if_ccip_c1_Rx cp2af_sRx_c1;
  t_if_ccip_c1_Tx af2cp_sTx_c1;

  modport master (
    output wr_valid, wr_data, c1TxAlmFull, cp2af_sRx_c1,
    input  wr_ready, af2cp_sTx_c1
  );

  modport slave (
    input  wr_valid, wr_data, c1TxAlmFull, cp2af_sRx_c1,
    output wr_ready, af2cp_sTx_c1
  );

endinterface

`default_nettype wire

// File: rtl/pipearch_writeback_fifo.sv
// ---------------------------------------------------------------------------
// pipearch_writeback_fifo
// First-word-fall-through line buffer. The caller never pushes when full
// and never pops when empty; count_o reports the current occupancy.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipearch_writeback_fifo #(
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 6
) (
  input  wire logic                  clk_i,
  input  wire logic                  reset_i,
  input  wire logic                  push_i,
  input  wire logic [WIDTH-1:0]      data_i,
  input  wire logic                  pop_i,
  output logic      [WIDTH-1:0]      data_o,
  output logic      [LOG2_DEPTH:0]   count_o
);

  localparam logic [LOG2_DEPTH:0] CNT_ONE = (LOG2_DEPTH+1)'(1);

  logic [WIDTH-1:0]      mem_q [1 << LOG2_DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] rd_ptr_q;
  logic [LOG2_DEPTH:0]   count_q;

  // Line storage, no reset so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + CNT_ONE;
      else if (!push_i && pop_i) count_q <= count_q - CNT_ONE;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipearch_writeback.sv
// ---------------------------------------------------------------------------
// pipearch_writeback
// Buffers engine lines and issues CCI-P c1 write requests to consecutive
// lines from in_addr+regs[5], coalescing aligned 2/4-line bursts when
// enabled. Counts write responses and pulses op_done when all lines are
// acknowledged.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipearch_writeback
  import pipearch_writeback_pkg::*;
#(
  parameter int LOG2_DEPTH = LOG2_WRITEBUF_SIZE
) (
  input  wire logic                          clk_i,
  input  wire logic                          reset_i,
  input  wire logic                          op_start_i,
  output logic                               op_done_o,
  input  wire logic [NUM_REGS-1:0][31:0]     regs_i,
  input  wire t_ccip_clAddr                  in_addr_i,
  pipearch_writeback_if.slave                wb_if
);

  localparam int                  DEPTH     = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] CNT_ONE   = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH:0] CNT_TWO   = (LOG2_DEPTH+1)'(2);
  localparam logic [LOG2_DEPTH:0] CNT_FOUR  = (LOG2_DEPTH+1)'(4);
  localparam logic [LOG2_DEPTH:0] CNT_LIMIT = (LOG2_DEPTH+1)'(DEPTH-1);

  logic [1:0]          state_q, state_d;
  t_ccip_clAddr        next_addr_q, next_addr_d;
  t_ccip_clAddr        burst_base_q, burst_base_d;
  logic [30:0]         length_q, length_d;
  logic                multi_q, multi_d;
  logic [31:0]         accepted_q, accepted_d;
  logic [31:0]         issued_q, issued_d;
  logic [31:0]         resp_q, resp_d;
  logic                wr_ready_q, wr_ready_d;
  logic                burst_active_q, burst_active_d;
  logic [1:0]          beat_q, beat_d;
  logic [1:0]          last_beat_q, last_beat_d;
  t_ccip_clLen         cl_len_q, cl_len_d;
  logic [15:0]         mdata_q, mdata_d;
  t_if_ccip_c1_Tx      tx_q, tx_d;

  logic                w_push, w_pop, w_can_start;
  logic                w_start4, w_start2, w_start1, w_start;
  logic [31:0]         w_len32;
  logic [LOG2_DEPTH:0] w_count, w_count_d;
  t_ccip_clData        w_head;
  t_ccip_clLen         w_len_sel;
  logic                w_unused;

  pipearch_writeback_fifo #(
    .WIDTH      (512),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .data_i  (wb_if.wr_data),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count)
  );

  // Burst selection: widest aligned burst the buffer and remaining length allow
  always_comb begin
    w_len32     = {1'b0, length_q};
    w_push      = wb_if.wr_valid && wr_ready_q;
    w_can_start = (state_q == S_WRITE) && !burst_active_q && !wb_if.c1TxAlmFull;
    w_start4    = w_can_start && multi_q && (next_addr_q[1:0] == 2'b00) &&
                  (issued_q + 32'd4 <= w_len32) && (w_count >= CNT_FOUR);
    w_start2    = w_can_start && !w_start4 && multi_q && !next_addr_q[0] &&
                  (issued_q + 32'd2 <= w_len32) && (w_count >= CNT_TWO);
    w_start1    = w_can_start && !w_start4 && !w_start2 && (w_count >= CNT_ONE);
    w_start     = w_start4 || w_start2 || w_start1;
    w_pop       = w_start || burst_active_q;
    w_len_sel   = w_start4 ? eCL_LEN_4 : (w_start2 ? eCL_LEN_2 : eCL_LEN_1);
    w_count_d   = w_count;
    if (w_push && !w_pop)      w_count_d = w_count + CNT_ONE;
    else if (!w_push && w_pop) w_count_d = w_count - CNT_ONE;
  end

  // Next-state: op control, counters, burst sequencer and c1 request
  always_comb begin
    state_d        = state_q;
    next_addr_d    = next_addr_q;
    burst_base_d   = burst_base_q;
    length_d       = length_q;
    multi_d        = multi_q;
    accepted_d     = accepted_q + (w_push ? 32'd1 : 32'd0);
    issued_d       = issued_q + (w_pop ? 32'd1 : 32'd0);
    resp_d         = resp_q;
    burst_active_d = burst_active_q;
    beat_d         = beat_q;
    last_beat_d    = last_beat_q;
    cl_len_d       = cl_len_q;
    mdata_d        = mdata_q;
    tx_d           = '0;

    case (state_q)
      S_IDLE: begin
        if (op_start_i) begin
          state_d     = S_WRITE;
          next_addr_d = in_addr_i + t_ccip_clAddr'(regs_i[5]);
          length_d    = regs_i[6][30:0];
          multi_d     = regs_i[6][31];
          accepted_d  = '0;
          issued_d    = '0;
          resp_d      = '0;
        end
      end
      S_WRITE: begin
        if (cci_c1Rx_isWriteRsp(wb_if.cp2af_sRx_c1))
          resp_d = resp_q + rsp_line_count(wb_if.cp2af_sRx_c1);
        if (resp_q == w_len32) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_pop) begin
      tx_d.valid        = 1'b1;
      tx_d.data         = w_head;
      tx_d.hdr.req_type = eREQ_WRLINE_I;
      tx_d.hdr.vc_sel   = eVC_VA;
      next_addr_d       = next_addr_q + t_ccip_clAddr'(1);
      if (w_start) begin
        tx_d.hdr.sop     = 1'b1;
        tx_d.hdr.address = next_addr_q;
        tx_d.hdr.cl_len  = w_len_sel;
        tx_d.hdr.mdata   = issued_q[15:0];
        burst_base_d     = next_addr_q;
        cl_len_d         = w_len_sel;
        mdata_d          = issued_q[15:0];
        burst_active_d   = !w_start1;
        beat_d           = 2'd1;
        last_beat_d      = w_start4 ? 2'd3 : 2'd1;
      end else begin
        // Continuation beats carry the beat index in address[1:0]
        tx_d.hdr.sop     = 1'b0;
        tx_d.hdr.address = {burst_base_q[CL_ADDR_W-1:2], beat_q};
        tx_d.hdr.cl_len  = cl_len_q;
        tx_d.hdr.mdata   = mdata_q;
        beat_d           = beat_q + 2'd1;
        if (beat_q == last_beat_q) burst_active_d = 1'b0;
      end
    end

    // One line of slack: ready is computed from the post-edge occupancy
    wr_ready_d = (state_d == S_WRITE) && (accepted_d < {1'b0, length_d}) &&
                 (w_count_d < CNT_LIMIT);
  end

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      next_addr_q    <= '0;
      burst_base_q   <= '0;
      length_q       <= '0;
      multi_q        <= 1'b0;
      accepted_q     <= '0;
      issued_q       <= '0;
      resp_q         <= '0;
      wr_ready_q     <= 1'b0;
      burst_active_q <= 1'b0;
      beat_q         <= '0;
      last_beat_q    <= '0;
      cl_len_q       <= eCL_LEN_1;
      mdata_q        <= '0;
      tx_q           <= '0;
    end else begin
      state_q        <= state_d;
      next_addr_q    <= next_addr_d;
      burst_base_q   <= burst_base_d;
      length_q       <= length_d;
      multi_q        <= multi_d;
      accepted_q     <= accepted_d;
      issued_q       <= issued_d;
      resp_q         <= resp_d;
      wr_ready_q     <= wr_ready_d;
      burst_active_q <= burst_active_d;
      beat_q         <= beat_d;
      last_beat_q    <= last_beat_d;
      cl_len_q       <= cl_len_d;
      mdata_q        <= mdata_d;
      tx_q           <= tx_d;
    end
  end

  assign op_done_o          = (state_q == S_DONE);
  assign wb_if.wr_ready     = wr_ready_q;
  assign wb_if.af2cp_sTx_c1 = tx_q;
  assign w_unused           = ^{regs_i[4:0], regs_i[NUM_REGS-1:7]};

endmodule

`default_nettype wire

// File: tb/tb_pipearch_writeback.sv
// ---------------------------------------------------------------------------
// tb_pipearch_writeback
// Directed-vector bench for the writeback unit with hand-computed
// expected request streams and op_done behaviour.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pipearch_writeback;
  import pipearch_writeback_pkg::*;

  localparam int LOG2_DEPTH = 3;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      op_start = 1'b0;
  logic                      op_done;
  logic [NUM_REGS-1:0][31:0] regs = '0;
  t_ccip_clAddr              in_addr = '0;

  pipearch_writeback_if bus ();

  pipearch_writeback #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .op_start_i (op_start),
    .op_done_o  (op_done),
    .regs_i     (regs),
    .in_addr_i  (in_addr),
    .wb_if      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [41:0] addr;
    logic        sop;
    logic [1:0]  len;
    logic [15:0] mdata;
    logic [31:0] data;
  } t_rec;

  t_rec reqs[$];
  int   done_pulses = 0;
  int   fed = 0;

  // Request/op_done monitor, sampled just after the active edge
  always @(posedge clk) begin : mon
    t_rec r;
    #1;
    if (bus.af2cp_sTx_c1.valid) begin
      r.addr  = bus.af2cp_sTx_c1.hdr.address;
      r.sop   = bus.af2cp_sTx_c1.hdr.sop;
      r.len   = bus.af2cp_sTx_c1.hdr.cl_len;
      r.mdata = bus.af2cp_sTx_c1.hdr.mdata;
      r.data  = bus.af2cp_sTx_c1.data[31:0];
      reqs.push_back(r);
    end
    if (op_done) done_pulses++;
  end

  task automatic start_op(input t_ccip_clAddr a, input logic [31:0] off, input logic [31:0] r6);
    reqs.delete();
    done_pulses = 0;
    @(negedge clk);
    in_addr  = a;
    regs[5]  = off;
    regs[6]  = r6;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic feed(input int cnt, input int tag);
    int guard = 0;
    fed = 0;
    while (fed < cnt && guard < 400) begin
      @(negedge clk);
      guard++;
      bus.wr_valid = 1'b1;
      bus.wr_data  = {480'd0, 32'(tag + fed)};
      if (bus.wr_ready) fed++;
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("feed_all_accepted", 64'(fed), 64'(cnt));
  endtask

  task automatic send_rsp(input logic fmt, input logic [1:0] cln);
    @(negedge clk);
    bus.cp2af_sRx_c1.rspValid       = 1'b1;
    bus.cp2af_sRx_c1.hdr.format     = fmt;
    bus.cp2af_sRx_c1.hdr.cl_num     = cln;
    bus.cp2af_sRx_c1.hdr.resp_type  = eRSP_WRLINE;
    @(negedge clk);
    bus.cp2af_sRx_c1 = '0;
  endtask

  task automatic wait_done(input string tag);
    for (int g = 0; g < 20 && done_pulses == 0; g++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(tag, 64'(done_pulses), 64'd1);
  endtask

  task automatic wait_first_req(input string tag);
    for (int g = 0; g < 50 && reqs.size() == 0; g++) @(negedge clk);
    check(tag, 64'(reqs.size() > 0), 64'd1);
  endtask

  task automatic single_line(input string tag, input int dtag);
    start_op(42'h0F00, 32'h100, 32'd1);
    feed(1, dtag);
    repeat (5) @(negedge clk);
    check({tag, "_nreq"}, 64'(reqs.size()), 64'd1);
    if (reqs.size() == 1) begin
      check({tag, "_addr"}, 64'(reqs[0].addr), 64'h1000);
      check({tag, "_sop"}, 64'(reqs[0].sop), 64'd1);
      check({tag, "_len"}, 64'(reqs[0].len), 64'(eCL_LEN_1));
      check({tag, "_mdata"}, 64'(reqs[0].mdata), 64'd0);
      check({tag, "_data"}, 64'(reqs[0].data), 64'(dtag));
    end
    send_rsp(1'b0, 2'd0);
    check({tag, "_done_early"}, 64'(op_done), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(op_done), 64'd1);
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done_pulses), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.wr_valid     = 1'b0;
    bus.wr_data      = '0;
    bus.c1TxAlmFull  = 1'b0;
    bus.cp2af_sRx_c1 = '0;
    repeat (3) @(negedge clk);
    check("rst_op_done", 64'(op_done), 64'd0);
    check("rst_valid", 64'(bus.af2cp_sTx_c1.valid), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_hdr_zero", 64'(|bus.af2cp_sTx_c1.hdr), 64'd0);
    reset = 1'b0;

    // Single line at 0x0F00 + 0x100
    single_line("single", 100);

    // Aligned 8-line burst pair, data preloaded under almost-full
    bus.c1TxAlmFull = 1'b1;
    start_op(42'h2000, 32'd0, 32'h8000_0008);
    fork
      feed(8, 200);
      begin
        repeat (15) @(negedge clk);
        check("aln_full_ready", 64'(bus.wr_ready), 64'd0);
        check("aln_full_fed", 64'(fed), 64'd7);
        check("aln_no_req_almfull", 64'(reqs.size()), 64'd0);
        bus.c1TxAlmFull = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("aln_nreq", 64'(reqs.size()), 64'd8);
    for (int i = 0; i < 8 && i < reqs.size(); i++) begin
      check($sformatf("aln_addr%0d", i), 64'(reqs[i].addr), 64'h2000 + 64'(i));
      check($sformatf("aln_sop%0d", i), 64'(reqs[i].sop), 64'((i % 4) == 0));
      check($sformatf("aln_len%0d", i), 64'(reqs[i].len), 64'(eCL_LEN_4));
      check($sformatf("aln_data%0d", i), 64'(reqs[i].data), 64'(200 + i));
    end
    if (reqs.size() == 8) begin
      check("aln_mdata0", 64'(reqs[0].mdata), 64'd0);
      check("aln_mdata4", 64'(reqs[4].mdata), 64'd4);
    end
    for (int i = 0; i < 8; i++) send_rsp(1'b0, 2'd0);
    wait_done("aln_done");

    // Misaligned start: LEN_1 @3001, LEN_2 @3002, LEN_4 @3004
    bus.c1TxAlmFull = 1'b1;
    start_op(42'h3001, 32'd0, 32'h8000_0007);
    fork
      feed(7, 300);
      begin
        repeat (15) @(negedge clk);
        bus.c1TxAlmFull = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("mis_nreq", 64'(reqs.size()), 64'd7);
    if (reqs.size() == 7) begin
      check("mis_a0", 64'(reqs[0].addr), 64'h3001);
      check("mis_l0", 64'(reqs[0].len), 64'(eCL_LEN_1));
      check("mis_s0", 64'(reqs[0].sop), 64'd1);
      check("mis_a1", 64'(reqs[1].addr), 64'h3002);
      check("mis_l1", 64'(reqs[1].len), 64'(eCL_LEN_2));
      check("mis_m1", 64'(reqs[1].mdata), 64'd1);
      check("mis_s2", 64'(reqs[2].sop), 64'd0);
      check("mis_l2", 64'(reqs[2].len), 64'(eCL_LEN_2));
      check("mis_a3", 64'(reqs[3].addr), 64'h3004);
      check("mis_l3", 64'(reqs[3].len), 64'(eCL_LEN_4));
      check("mis_m3", 64'(reqs[3].mdata), 64'd3);
      check("mis_a6", 64'(reqs[6].addr), 64'h3007);
      check("mis_s6", 64'(reqs[6].sop), 64'd0);
      for (int i = 0; i < 7; i++)
        check($sformatf("mis_data%0d", i), 64'(reqs[i].data), 64'(300 + i));
    end
    send_rsp(1'b0, 2'd0);
    send_rsp(1'b1, 2'd1);
    send_rsp(1'b1, 2'd3);
    wait_done("mis_done");

    // Backpressure mid-stream: active burst finishes, no new burst starts
    bus.c1TxAlmFull = 1'b1;
    start_op(42'h4000, 32'd0, 32'h8000_0010);
    fork
      feed(16, 400);
      begin
        repeat (15) @(negedge clk);
        bus.c1TxAlmFull = 1'b0;
        wait_first_req("bp_first_req");
        bus.c1TxAlmFull = 1'b1;
        repeat (20) @(negedge clk);
        check("bp_burst_complete", 64'(reqs.size()), 64'd4);
        check("bp_ready_low", 64'(bus.wr_ready), 64'd0);
        check("bp_fed_fill", 64'(fed), 64'd11);
        bus.c1TxAlmFull = 1'b0;
      end
    join
    repeat (30) @(negedge clk);
    check("bp_nreq", 64'(reqs.size()), 64'd16);
    for (int i = 0; i < 16 && i < reqs.size(); i++)
      check($sformatf("bp_data%0d", i), 64'(reqs[i].data), 64'(400 + i));
    for (int i = 0; i < 16; i++) send_rsp(1'b0, 2'd0);
    wait_done("bp_done");

    // One packed response acknowledges a 4-line burst
    bus.c1TxAlmFull = 1'b1;
    start_op(42'h5000, 32'd0, 32'h8000_0004);
    fork
      feed(4, 500);
      begin
        repeat (10) @(negedge clk);
        bus.c1TxAlmFull = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    check("pk_nreq", 64'(reqs.size()), 64'd4);
    if (reqs.size() == 4) begin
      check("pk_addr0", 64'(reqs[0].addr), 64'h5000);
      check("pk_len0", 64'(reqs[0].len), 64'(eCL_LEN_4));
    end
    check("pk_no_early_done", 64'(done_pulses), 64'd0);
    send_rsp(1'b1, 2'd3);
    wait_done("pk_done");

    // Zero-length operation
    start_op(42'h6000, 32'd0, 32'h8000_0000);
    repeat (6) @(negedge clk);
    check("zero_nreq", 64'(reqs.size()), 64'd0);
    check("zero_done", 64'(done_pulses), 64'd1);

    // Asynchronous reset in the middle of a burst
    bus.c1TxAlmFull = 1'b1;
    start_op(42'h7000, 32'd0, 32'h8000_0008);
    feed(7, 700);
    bus.c1TxAlmFull = 1'b0;
    wait_first_req("rst_first_req");
    check("rst_pre_valid", 64'(bus.af2cp_sTx_c1.valid), 64'd1);
    check("rst_pre_ready", 64'(bus.wr_ready), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.af2cp_sTx_c1.valid), 64'd0);
    check("midrst_op_done", 64'(op_done), 64'd0);
    check("midrst_wr_ready", 64'(bus.wr_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send_rsp(1'b1, 2'd3);
    repeat (3) @(negedge clk);
    check("midrst_stale_rsp", 64'(done_pulses), 64'd0);

    // Clean run after reset
    single_line("post_rst", 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
